// File: rtl/fir4_out_decim_buf.sv
// Rounded-mean output stage for the 4-tap FIR: divides each sum by 4, keeps one of every DECIM samples and buffers them in a FIFO.
// Optional macro FIR4_OB_DROPCNT_EN builds the saturating dropped-push counter behind drop_cnt.
module fir4_out_decim_buf #(
  parameter int w     = 16,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [w+1:0]             s_in,
  input  logic                     s_valid,
  input  logic                     clr,
  output logic [w-1:0]             y,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Round-half-up divide by 4 at w+3 bits, truncated to w bits.
  function automatic logic [w-1:0] round_mean(input logic [w+1:0] s);
    logic [w+2:0] t;
    t = {1'b0, s} + {{(w+1){1'b0}}, 2'b10};
    return t[w+1:2];
  endfunction

  logic [w-1:0]  mem_r [DEPTH];
  logic [LW-1:0] wr_ptr_r;
  logic [LW-1:0] rd_ptr_r;
  logic [PW-1:0] phase_r;
  logic [w-1:0]  y_r;
  logic          y_valid_r;
  logic [LW-1:0] level_r;
  logic          ovf_r;

  logic [w-1:0]  m_s;
  logic          last_s;
  logic          pop_s;
  logic          push_req_s;
  logic          push_ok_s;
  logic          drop_s;
  logic          full_s;
  logic [LW-1:0] wr_nxt_s;
  logic [LW-1:0] rd_nxt_s;
  logic [LW-1:0] level_nxt_s;
  logic [w-1:0]  y_nxt_s;

  // Handshake decode, next pointers and the next FIFO head; clr masks every transfer.
  always_comb begin
    m_s         = round_mean(s_in);
    last_s      = (phase_r == PW'(DECIM - 1));
    full_s      = (level_r == LW'(DEPTH));
    pop_s       = y_valid_r & y_ready & ~clr;
    push_req_s  = s_valid & last_s & ~clr;
    push_ok_s   = push_req_s & (~full_s | pop_s);
    drop_s      = push_req_s & ~push_ok_s;
    wr_nxt_s    = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
    rd_nxt_s    = rd_ptr_r + {{AW{1'b0}}, pop_s};
    level_nxt_s = wr_nxt_s - rd_nxt_s;
    y_nxt_s     = {w{1'b0}};
    // A push into an empty FIFO lands in the slot the read pointer will address next.
    if (level_nxt_s == {LW{1'b0}}) begin
      y_nxt_s = {w{1'b0}};
    end else if (push_ok_s && (rd_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      y_nxt_s = m_s;
    end else begin
      y_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  // FIFO storage; contents are never exposed while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= m_s;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // Pointers, registered outputs and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r  <= {LW{1'b0}};
      rd_ptr_r  <= {LW{1'b0}};
      level_r   <= {LW{1'b0}};
      y_valid_r <= 1'b0;
      y_r       <= {w{1'b0}};
      ovf_r     <= 1'b0;
    end else if (clr) begin
      wr_ptr_r  <= {LW{1'b0}};
      rd_ptr_r  <= {LW{1'b0}};
      level_r   <= {LW{1'b0}};
      y_valid_r <= 1'b0;
      y_r       <= {w{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_nxt_s;
      rd_ptr_r  <= rd_nxt_s;
      level_r   <= level_nxt_s;
      y_valid_r <= (level_nxt_s != {LW{1'b0}});
      y_r       <= y_nxt_s;
      ovf_r     <= ovf_r | drop_s;
    end
  end

  // Decimation phase: counts valid samples, wrapping after the last of each group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= {PW{1'b0}};
    end else if (clr) begin
      phase_r <= {PW{1'b0}};
    end else if (s_valid) begin
      if (last_s) begin
        phase_r <= {PW{1'b0}};
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end else begin
      phase_r <= phase_r;
    end
  end

`ifdef FIR4_OB_DROPCNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of pushes lost to a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= 8'd0;
    end else if (clr) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 8'd0;
`endif

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign level   = level_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_fir4_out_decim_buf.sv
// Directed bench for fir4_out_decim_buf: a DECIM=2 and a DECIM=1 instance share one stimulus bus.
module tb_fir4_out_decim_buf;
  localparam int W = 16;

`ifdef FIR4_OB_DROPCNT_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [W+1:0]   s_in;
  logic           s_valid;
  logic           clr;
  logic           y_ready;

  logic [W-1:0]   y1, y2;
  logic           yv1, yv2;
  logic [2:0]     lv1, lv2;
  logic           ovf1, ovf2;
  logic [7:0]     dc1, dc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir4_out_decim_buf #(.w(W), .DECIM(2), .DEPTH(4)) u_d2 (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .clr(clr),
    .y(y2), .y_valid(yv2), .y_ready(y_ready), .level(lv2), .ovf(ovf2), .drop_cnt(dc2));

  fir4_out_decim_buf #(.w(W), .DECIM(1), .DEPTH(4)) u_d1 (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .clr(clr),
    .y(y1), .y_valid(yv1), .y_ready(y_ready), .level(lv1), .ovf(ovf1), .drop_cnt(dc1));

  typedef struct {
    logic         sel;   // 1: DECIM=1 instance, 0: DECIM=2 instance
    logic         sv;
    logic [W+1:0] si;
    logic         rdy;
    logic         c;
    logic         ev;
    logic [W-1:0] ey;
    logic [2:0]   el;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [W+1:0] si, input logic rdy, input logic c);
    s_valid = sv;
    s_in    = si;
    y_ready = rdy;
    clr     = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 18'd4,      1'b1, 1'b0, 1'b0, 16'd0,     3'd0};
    tbl[1]  = '{1'b0, 1'b1, 18'd8,      1'b1, 1'b0, 1'b1, 16'd2,     3'd1};
    tbl[2]  = '{1'b0, 1'b1, 18'd13,     1'b1, 1'b0, 1'b0, 16'd0,     3'd0};
    tbl[3]  = '{1'b0, 1'b1, 18'd262140, 1'b1, 1'b0, 1'b1, 16'd65535, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 18'd0,      1'b1, 1'b0, 1'b0, 16'd0,     3'd0};
    tbl[5]  = '{1'b1, 1'b0, 18'd0,      1'b1, 1'b1, 1'b0, 16'd0,     3'd0};
    tbl[6]  = '{1'b1, 1'b1, 18'd1,      1'b1, 1'b0, 1'b1, 16'd0,     3'd1};
    tbl[7]  = '{1'b1, 1'b1, 18'd2,      1'b1, 1'b0, 1'b1, 16'd1,     3'd1};
    tbl[8]  = '{1'b1, 1'b1, 18'd5,      1'b1, 1'b0, 1'b1, 16'd1,     3'd1};
    tbl[9]  = '{1'b1, 1'b1, 18'd6,      1'b1, 1'b0, 1'b1, 16'd2,     3'd1};
    tbl[10] = '{1'b1, 1'b0, 18'd0,      1'b1, 1'b0, 1'b0, 16'd0,     3'd0};

    // Reset state
    reset = 1'b0;
    drive(1'b0, 18'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y1), 32'd0);
    chk("rst_yv", 32'(yv1), 32'd0);
    chk("rst_level", 32'(lv1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_drop", 32'(dc1), 32'd0);
    chk("rst_yv_d2", 32'(yv2), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table: decimated stream then rounding
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].sv, tbl[i].si, tbl[i].rdy, tbl[i].c);
      tick();
      if (tbl[i].sel) begin
        chk($sformatf("vec%0d_yv", i), 32'(yv1), 32'(tbl[i].ev));
        chk($sformatf("vec%0d_y", i), 32'(y1), 32'(tbl[i].ey));
        chk($sformatf("vec%0d_level", i), 32'(lv1), 32'(tbl[i].el));
      end else begin
        chk($sformatf("vec%0d_yv", i), 32'(yv2), 32'(tbl[i].ev));
        chk($sformatf("vec%0d_y", i), 32'(y2), 32'(tbl[i].ey));
        chk($sformatf("vec%0d_level", i), 32'(lv2), 32'(tbl[i].el));
      end
    end

    // Fill and overflow, then drain
    drive(1'b0, 18'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 18'(4 * (k + 1)), 1'b0, 1'b0);
      tick();
    end
    chk("ovf_level", 32'(lv1), 32'd4);
    chk("ovf_y", 32'(y1), 32'd1);
    chk("ovf_flag", 32'(ovf1), 32'd1);
    chk("ovf_drop", 32'(dc1), 32'(EXP_DROP));
    drive(1'b0, 18'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_yv", k), 32'(yv1), 32'd1);
      chk($sformatf("drain%0d_y", k), 32'(y1), 32'(k + 1));
      tick();
    end
    chk("drain_empty", 32'(yv1), 32'd0);
    chk("drain_empty_y", 32'(y1), 32'd0);
    chk("ovf_sticky", 32'(ovf1), 32'd1);

    // Full FIFO with simultaneous push and pop
    drive(1'b0, 18'd0, 1'b0, 1'b1);
    tick();
    chk("clr_ovf", 32'(ovf1), 32'd0);
    chk("clr_drop", 32'(dc1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 18'(4 * (k + 1)), 1'b0, 1'b0);
      tick();
    end
    chk("full_level", 32'(lv1), 32'd4);
    drive(1'b1, 18'd40, 1'b1, 1'b0);
    tick();
    chk("pp_level", 32'(lv1), 32'd4);
    chk("pp_ovf", 32'(ovf1), 32'd0);
    chk("pp_y", 32'(y1), 32'd2);
    drive(1'b0, 18'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp_drain%0d", k), 32'(y1), (k == 3) ? 32'd10 : 32'(k + 2));
      tick();
    end
    chk("pp_empty", 32'(yv1), 32'd0);

    // s_valid gaps on DECIM=2
    drive(1'b0, 18'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 18'd8, 1'b0, 1'b0);
    tick();
    chk("gap_first", 32'(lv2), 32'd0);
    drive(1'b0, 18'($urandom), 1'b0, 1'b0);
    tick();
    drive(1'b0, 18'($urandom), 1'b0, 1'b0);
    tick();
    chk("gap_idle", 32'(lv2), 32'd0);
    drive(1'b1, 18'd16, 1'b0, 1'b0);
    tick();
    chk("gap_level", 32'(lv2), 32'd1);
    chk("gap_y", 32'(y2), 32'd4);
    chk("gap_yv", 32'(yv2), 32'd1);

    // clr with level=2 and a half-finished group
    drive(1'b1, 18'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 18'd8, 1'b0, 1'b0);
    tick();
    drive(1'b1, 18'd12, 1'b0, 1'b0);
    tick();
    chk("preclr_level", 32'(lv2), 32'd2);
    drive(1'b1, 18'd100, 1'b1, 1'b1);
    tick();
    chk("clr_yv", 32'(yv2), 32'd0);
    chk("clr_level", 32'(lv2), 32'd0);
    drive(1'b1, 18'd20, 1'b0, 1'b0);
    tick();
    chk("clr_phase0", 32'(lv2), 32'd0);
    drive(1'b1, 18'd24, 1'b0, 1'b0);
    tick();
    chk("clr_group_level", 32'(lv2), 32'd1);
    chk("clr_group_y", 32'(y2), 32'd6);

    // Async reset mid-drain with level=3
    drive(1'b0, 18'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 18'(4 * (k + 1)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 18'd0, 1'b1, 1'b0);
    tick();
    chk("mid_level", 32'(lv1), 32'd3);
    chk("mid_ovf", 32'(ovf1), 32'd1);
    reset = 1'b0;
    #2;
    chk("arst_yv", 32'(yv1), 32'd0);
    chk("arst_level", 32'(lv1), 32'd0);
    chk("arst_ovf", 32'(ovf1), 32'd0);
    chk("arst_y", 32'(y1), 32'd0);
    chk("arst_level_d2", 32'(lv2), 32'd0);
    #1;
    reset = 1'b1;
    drive(1'b1, 18'd8, 1'b0, 1'b0);
    tick();
    chk("post_rst_level", 32'(lv1), 32'd1);
    chk("post_rst_y", 32'(y1), 32'd2);
    chk("post_rst_d2", 32'(lv2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir4_out_decim_buf.md
Name: fir4_out_decim_buf

Overview:
- Output stage directly downstream of the 4-tap moving-sum FIR.
- Each cycle it takes the FIR's (w+2)-bit unsigned sum and divides it by 4 with rounding, giving a w-bit mean.
- It keeps one mean out of every DECIM valid samples and stores the kept means in a small FIFO.
- A downstream consumer drains the FIFO over a valid/ready handshake. Overflow is detected and flagged.

Parameters:
- w, 16: FIR input sample width. Input sum is w+2 bits; output mean is w bits.
- DECIM, 2: decimation factor. Legal range 1..16; DECIM=1 keeps every sample.
- DEPTH, 4: FIFO depth in entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset. Low forces every register to its reset value immediately, regardless of clk.
- s_in  in  w+2  unsigned moving sum from the FIR.
- s_valid  in  1  s_in carries a new sample this cycle.
- clr  in  1  synchronous flush of FIFO and decimation phase. Active high.
- y  out  w  FIFO head (rounded mean).
- y_valid  out  1  FIFO non-empty; y is meaningful.
- y_ready  in  1  consumer accepts y this cycle.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky overflow flag. Cleared by reset or clr.
- drop_cnt  out  8  dropped-sample count (see Optional Feature).

Behaviour:
- Reset values: y=0, y_valid=0, level=0, ovf=0, drop_cnt=0, phase=0, read/write pointers=0. Storage contents are don't-care but must never be visible while y_valid=0; y reads 0 when empty.
- Arithmetic: m = (s_in + 2) >> 2, computed at w+3 bits, then truncated to w bits.
  - Round-half-up. Maximum legal input 4*(2^w-1) gives 2^w-1, so no saturation is needed.
  - Inputs above 4*(2^w-1) are out of contract; result is truncated.
- Phase counter:
  - 0..DECIM-1. Advances only on s_valid=1; wraps from DECIM-1 to 0.
  - A push is requested when s_valid=1 and phase==DECIM-1 (the last sample of each group).
- Push/pop rules:
  - Pop occurs when y_valid=1 and y_ready=1.
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the push is dropped: ovf<=1, and drop_cnt increments, saturating at 255.
  - Simultaneous push and pop when non-empty and non-full: level unchanged.
  - Push on empty: y_valid rises the cycle after the push edge. There is no combinational bypass; minimum latency is 1 clock from the accepted s_in edge to y_valid.
  - y_ready while y_valid=0 has no effect.
- Pointers: wrap modulo DEPTH. level = write count minus read count, range 0..DEPTH. Full when level==DEPTH.
- Output stability: while y_valid=1 and y_ready=0, y holds its value.
- clr:
  - Next edge sets phase=0, level=0, y_valid=0, ovf=0, drop_cnt=0.
  - An s_valid or pop in the same cycle is ignored; clr has priority.
- Mid-operation reset (reset low at any time): state returns to reset values asynchronously. The first edge after deassertion behaves as post-reset.
- No state other than the FIFO, pointers, phase, ovf and drop_cnt. Everything is clocked on clk only.

Optional Feature:
- Macro FIR4_OB_DROPCNT_EN.
- Defined: drop_cnt is an 8-bit saturating counter of dropped pushes, cleared by reset or clr.
- Undefined: no counter register is built, drop_cnt is tied to 0, and ovf still works.

Test Plan:
- Reset then DECIM=2, y_ready=1, s_valid=1, s_in=4,8,13,262140 on consecutive cycles -> y=2 then 65535. Each y_valid pulse lasts 1 cycle and starts 1 clock after the push edge.
- Rounding: DECIM=1, s_in=1,2,5,6 -> y=0,1,1,2.
- Fill/overflow: DECIM=1, DEPTH=4, y_ready=0, 6 valid samples s_in=4,8,12,16,20,24 -> level=4, y=1, ovf=1. drop_cnt=2 with macro, 0 without. Then y_ready=1 drains 1,2,3,4.
- Full with simultaneous push/pop: level=4, y_ready=1 and push s_in=40 in the same cycle -> accepted, level stays 4, ovf unchanged, 10 appears last.
- s_valid gaps: DECIM=2, s_valid pattern 1,0,0,1 with s_in 8,x,x,16 -> single push, y=4.
- Async reset asserted mid-drain with level=3 -> y_valid, level and ovf drop to 0 before the next clk edge. clr with level=2 -> y_valid=0 next cycle, and the next push lands after a full DECIM group.
